// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// opcode constants, FSM state type and the access legality rule.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Size/alignment legality of one access. Range checking is left to the
    // caller because it depends on the RAM depth.
    function automatic logic access_ok(input logic [2:0] funct3,
                                       input logic       is_store,
                                       input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~lane[0];
            F3_W:    ok = (lane == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~lane[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data RAM (little-endian, lane = addr[1:0]).
// Stores: byte enables plus the store data replicated onto every lane.
// Loads: picks the addressed byte/half out of the word and sign- or
// zero-extends it.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension for both directions.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = '0;
        w_byte  = i_rword[{i_lane, 3'b000} +: 8];
        w_half  = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
        case (i_funct3)
            F3_B: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            F3_BU: o_rdata = {24'd0, w_byte};
            F3_H: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_half[15]}}, w_half};
            end
            F3_HU: o_rdata = {16'd0, w_half};
            F3_W: begin
                o_be    = 4'b1111;
                o_rdata = i_rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: services one LOAD/STORE at a time against a
// word-organised RAM with fixed latency. busy stalls the datapath, done
// pulses for one cycle with rdata/err valid.
// Optional build macro DMEM_STATS_EN adds saturating load/store/error
// counters on load_cnt, store_cnt and err_cnt.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        funct3,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       load_cnt,
    output logic [15:0]       store_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t      r_state;
    dmem_state_t      w_state_next;

    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_lane;
    logic [31:0]      r_wdata;
    logic [2:0]       r_funct3;
    logic             r_is_store;
    logic [3:0]       r_cnt;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_req;
    logic             w_oob;
    logic             w_legal;
    logic             w_access;
    logic             w_mem_we;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_sh;
    logic [31:0]      w_load_ext;
    logic [31:0]      w_rword;

    // A request is exactly one strobe; both at once is a conflict and is
    // rejected along with misaligned, unknown-size or out-of-range accesses.
    assign w_req    = mem_read ^ mem_write;
    assign w_oob    = |addr[ADDR_W-1:IDX_W+2];
    assign w_legal  = w_req && !w_oob && access_ok(funct3, mem_write, addr[1:0]);
    assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
    // Reset during the access cycle discards the pending store.
    assign w_mem_we = rst_n && w_access && r_is_store;
    assign w_rword  = r_mem[r_idx];

    dmem_lane_align u_lane_align (
        .i_funct3 (r_funct3),
        .i_lane   (r_lane),
        .i_wdata  (r_wdata),
        .i_rword  (w_rword),
        .o_be     (w_be),
        .o_wdata  (w_wdata_sh),
        .o_rdata  (w_load_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state and handshake outputs; busy is combinational so the
    // datapath stalls already in the request cycle.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    busy         = 1'b1;
                    w_state_next = w_legal ? WAIT : RESP;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (r_cnt == 4'd0) w_state_next = RESP;
            end
            RESP: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch, latency counter and response registers. rdata/err
    // default to zero so they are only non-zero during RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_lane     <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
            r_is_store <= 1'b0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        r_idx      <= addr[IDX_W+1:2];
                        r_lane     <= addr[1:0];
                        r_wdata    <= wdata;
                        r_funct3   <= funct3;
                        r_is_store <= mem_write;
                        r_cnt      <= CNT_INIT;
                        r_err      <= ~w_legal;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_is_store) r_rdata <= w_load_ext;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM write port with per-byte enables.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents survive rst_n and
        // only the write enable is qualified by it.
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[r_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
            end
        end
    end

    assign rdata = r_rdata;
    assign err   = r_err;

`ifdef DMEM_STATS_EN
    logic [15:0] r_load_cnt;
    logic [15:0] r_store_cnt;
    logic [15:0] r_err_cnt;

    // Saturating completion counters, bumped once per RESP cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (r_state == RESP) begin
            if (r_err) begin
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end else if (r_is_store) begin
                if (r_store_cnt != 16'hFFFF) r_store_cnt <= r_store_cnt + 16'd1;
            end else begin
                if (r_load_cnt != 16'hFFFF) r_load_cnt <= r_load_cnt + 16'd1;
            end
        end
    end

    assign load_cnt  = r_load_cnt;
    assign store_cnt = r_store_cnt;
    assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized accesses
// checked against a byte-array reference model of the RAM.
// Optional build macro DMEM_STATS_EN also exercises the statistics counters.
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int ADDR_W  = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
`ifdef DMEM_STATS_EN
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;
    logic [15:0] err_cnt;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    logic [7:0]  ref_mem [DEPTH*4];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LATENCY),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .funct3    (funct3),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef DMEM_STATS_EN
        ,
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] f3, input bit wr);
        case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4: return wr ? 0 : 1;
            3'd5: return wr ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_legal(input bit rd, input bit wr,
                                     input logic [31:0] a, input logic [2:0] f3);
        int size;
        if (rd == wr) return 1'b0;
        if ((a / 4) >= DEPTH) return 1'b0;
        size = ref_size(f3, wr);
        if (size == 0) return 1'b0;
        return (a % size) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        longint v;
        int     size;
        size = ref_size(f3, 1'b0);
        v = 0;
        for (int i = 0; i < size; i++) v += longint'(ref_mem[a + i]) << (8 * i);
        if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v -= longint'(1) << (8 * size);
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        int size;
        size = ref_size(f3, 1'b1);
        for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
    endtask

    // One complete transaction. Entered and left #1 after a rising edge.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] f3,
                             input string name);
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_cyc;
        int          cyc;
        bit          busy_ok;
        bit          seen;
        exp_err   = !ref_legal(rd, wr, a, f3);
        exp_rdata = (!exp_err && rd) ? ref_load(a, f3) : 32'd0;
        exp_cyc   = exp_err ? 1 : LATENCY + 1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        funct3    = f3;
        cyc       = 0;
        busy_ok   = 1'b1;
        seen      = 1'b0;
        while (!seen && cyc <= 40) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles, required done at cycle %0d",
                     name, cyc, exp_cyc);
        end else begin
            if (cyc != exp_cyc) begin
                errors++;
                $display("FAIL %s done_cycle: got %0d required %0d", name, cyc, exp_cyc);
            end
            checks++;
            if (rdata !== exp_rdata) begin
                errors++;
                $display("FAIL %s rdata: got %h required %h (addr=%h f3=%0d)",
                         name, rdata, exp_rdata, a, f3);
            end
            checks++;
            if (err !== exp_err) begin
                errors++;
                $display("FAIL %s err: got %b required %b (addr=%h f3=%0d rd=%0d wr=%0d)",
                         name, err, exp_err, a, f3, rd, wr);
            end
            checks++;
            if (busy !== 1'b0 || !busy_ok) begin
                errors++;
                $display("FAIL %s busy: got resp-busy=%b wait-busy-ok=%0d required 0/1",
                         name, busy, busy_ok);
            end
        end
        last_rdata = rdata;
        last_err   = err;
        if (!exp_err && wr) ref_store(a, wd, f3);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] got, input logic [31:0] want, input string name);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (rdata !== 32'd0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rdata=%h done=%b err=%b busy=%b required all 0",
                     name, rdata, done, err, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        funct3    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int w = 0; w < DEPTH; w++)
            do_access(1'b0, 1'b1, 32'(w * 4), $urandom, 3'b010, "fill_sw");
    endtask

    task automatic test_directed();
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, "sw_10");
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "lw_10");
        expect_word(last_rdata, 32'hDEADBEEF, "lw_10_const");
        do_access(1'b0, 1'b1, 32'h10, 32'h0, 3'b010, "sw_10_zero");
        do_access(1'b0, 1'b1, 32'h13, 32'h80, 3'b000, "sb_13");
        do_access(1'b1, 1'b0, 32'h13, 32'h0, 3'b000, "lb_13");
        expect_word(last_rdata, 32'hFFFFFF80, "lb_13_const");
        do_access(1'b1, 1'b0, 32'h13, 32'h0, 3'b100, "lbu_13");
        expect_word(last_rdata, 32'h00000080, "lbu_13_const");
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "lw_10_after_sb");
        expect_word(last_rdata, 32'h80000000, "lw_10_after_sb_const");
        do_access(1'b1, 1'b0, 32'h11, 32'h0, 3'b001, "lh_misaligned");
        expect_word({31'd0, last_err}, 32'd1, "lh_misaligned_err");
        do_access(1'b0, 1'b1, 32'h12, 32'hCAFEF00D, 3'b010, "sw_misaligned");
        do_access(1'b1, 1'b1, 32'h10, 32'h12345678, 3'b010, "conflict");
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "lw_10_unchanged");
        expect_word(last_rdata, 32'h80000000, "lw_10_unchanged_const");
        do_access(1'b1, 1'b0, 32'h14, 32'h0, 3'b011, "ld_f3_011");
        do_access(1'b1, 1'b0, 32'(DEPTH * 4), 32'h0, 3'b010, "lw_oob");
        do_access(1'b0, 1'b1, 32'h22, 32'h0000A5C3, 3'b001, "sh_22");
        do_access(1'b1, 1'b0, 32'h22, 32'h0, 3'b001, "lh_22");
        expect_word(last_rdata, 32'hFFFFA5C3, "lh_22_const");
        do_access(1'b1, 1'b0, 32'h22, 32'h0, 3'b101, "lhu_22");
        expect_word(last_rdata, 32'h0000A5C3, "lhu_22_const");
    endtask

    task automatic test_reset_mid_store();
        do_access(1'b0, 1'b1, 32'h20, 32'h11111111, 3'b010, "sw_20");
        mem_write = 1'b1;
        addr      = 32'h20;
        wdata     = 32'h22222222;
        funct3    = 3'b010;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_outputs("reset_mid_store_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, "lw_20_after_reset");
        expect_word(last_rdata, 32'h11111111, "lw_20_after_reset_const");
    endtask

    task automatic test_random();
        bit          rd;
        bit          wr;
        logic [31:0] a;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                rd = 1'b1;
                wr = 1'b1;
            end else begin
                rd = $urandom_range(0, 1) == 1;
                wr = !rd;
            end
            case ($urandom_range(0, 15))
                0:       a = 32'(DEPTH * 4) + $urandom_range(0, 1023);
                1:       a = $urandom | 32'h8000_0000;
                default: a = $urandom_range(0, DEPTH * 4 - 1);
            endcase
            do_access(rd, wr, a, $urandom, 3'($urandom_range(0, 7)), "random");
        end
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_access(1'b0, 1'b1, 32'h40, 32'hA1B2C3D4, 3'b010, "stats_sw0");
        do_access(1'b0, 1'b1, 32'h44, 32'h01020304, 3'b010, "stats_sw1");
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, "stats_lw0");
        do_access(1'b1, 1'b0, 32'h44, 32'h0, 3'b010, "stats_lw1");
        do_access(1'b1, 1'b0, 32'h41, 32'h0, 3'b100, "stats_lbu");
        do_access(1'b1, 1'b0, 32'h43, 32'h0, 3'b001, "stats_lh_mis");
        @(negedge clk);
        expect_word({16'd0, load_cnt},  32'd3, "stats_load_cnt");
        expect_word({16'd0, store_cnt}, 32'd2, "stats_store_cnt");
        expect_word({16'd0, err_cnt},   32'd1, "stats_err_cnt");
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_reset_mid_store();
        test_random();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
